div_scale_engine: RTL and testbench

DIV_SCALE_ENGINE -- requirements
Module: div_scale_engine

---
 rtl/div_scale_pkg.sv | 17 +
 rtl/div_scale_lane.sv | 57 +++++
 rtl/div_scale_engine.sv | 120 ++++++++++++
 tb/tb_div_scale_engine.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/div_scale_pkg.sv
// Shared FSM encoding and default parameters for the divide/scale engine.
package div_scale_pkg;

  localparam int LANES_DEF  = 4;
  localparam int WORD_W_DEF = 32;
  localparam int SCALE_DEF  = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DIV   = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/div_scale_lane.sv
// One lane: q = sat(((a-cdf_min)*SCALE)/(b-cdf_min)) by restoring division.
// Operands captured on i_load, one quotient bit per i_step; no backpressure.
module div_scale_lane
  import div_scale_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int SCALE  = SCALE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [WORD_W-1:0] i_a,
  input  logic [WORD_W-1:0] i_b,
  input  logic [WORD_W-1:0] i_cdf_min,
  output logic [WORD_W-1:0] o_q
);

  localparam int SCALE_W = $clog2(SCALE + 1);
  localparam int NUM_W   = WORD_W + SCALE_W;

  logic [NUM_W-1:0]  r_quo;
  logic [WORD_W-1:0] r_rem;
  logic [WORD_W-1:0] r_div;
  logic              r_div_zero;
  logic [NUM_W-1:0]  w_num;
  logic [WORD_W:0]   w_shift;

  // A numerator below the offset clamps to zero before the divide starts.
  assign w_num   = (i_a < i_cdf_min) ? '0 : NUM_W'(i_a - i_cdf_min) * NUM_W'(SCALE);
  assign w_shift = {r_rem, r_quo[NUM_W-1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_quo      <= '0;
      r_rem      <= '0;
      r_div      <= '0;
      r_div_zero <= 1'b0;
    end else if (i_load) begin
      r_quo      <= w_num;
      r_rem      <= '0;
      r_div      <= i_b - i_cdf_min;
      r_div_zero <= (i_b <= i_cdf_min);
    end else if (i_step) begin
      if (w_shift >= {1'b0, r_div}) begin
        r_rem <= WORD_W'(w_shift - {1'b0, r_div});
        r_quo <= {r_quo[NUM_W-2:0], 1'b1};
      end else begin
        r_rem <= w_shift[WORD_W-1:0];
        r_quo <= {r_quo[NUM_W-2:0], 1'b0};
      end
    end
  end

  assign o_q = (r_div_zero || (r_quo > NUM_W'(SCALE))) ? WORD_W'(SCALE) : r_quo[WORD_W-1:0];

endmodule

// File: rtl/div_scale_engine.sv
// Walks NUM_WORDS memory words, scaling each lane through div_scale_lane.
// Latency NUM_W+3 cycles per word; enable low aborts to IDLE, no backpressure.
module div_scale_engine
  import div_scale_pkg::*;
#(
  parameter int LANES     = LANES_DEF,
  parameter int WORD_W    = WORD_W_DEF,
  parameter int ADDR_W    = 16,
  parameter int NUM_WORDS = 64,
  parameter int SCALE     = SCALE_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [WORD_W-1:0]       cdf_min,
  input  logic [LANES*WORD_W-1:0] div_sc_mem_rd_data1,
  input  logic [LANES*WORD_W-1:0] div_sc_mem_rd_data2,
  output logic [ADDR_W-1:0]       div_sc_mem_rd_addr1,
  output logic [ADDR_W-1:0]       div_sc_mem_rd_addr2,
  output logic [LANES*WORD_W-1:0] div_sc_mem_wt_data,
  output logic [ADDR_W-1:0]       div_sc_mem_wt_addr,
  output logic                    div_sc_mem_wt_en,
  output logic                    div_sc_mem_rd_done,
  output logic                    div_sc_mem_wt_done
);

  localparam int SCALE_W = $clog2(SCALE + 1);
  localparam int NUM_W   = WORD_W + SCALE_W;
  localparam int ITER_W  = $clog2(NUM_W);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(NUM_W - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_WORDS - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_index;
  logic [ITER_W-1:0] r_iter;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_wt_addr;
  logic              r_wt_en;
  logic              r_done;
  logic              w_load;
  logic              w_step;

  assign w_load = (r_state == ST_LOAD);
  assign w_step = (r_state == ST_DIV);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_index   <= '0;
      r_iter    <= '0;
      r_rd_addr <= '0;
      r_wt_addr <= '0;
      r_wt_en   <= 1'b0;
      r_done    <= 1'b0;
    end else if (!enable && r_state != ST_IDLE) begin
      r_state <= ST_IDLE;
      r_wt_en <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (enable) begin
          r_state   <= ST_READ;
          r_index   <= '0;
          r_rd_addr <= '0;
        end
        ST_READ: r_state <= ST_LOAD;
        ST_LOAD: begin
          r_state <= ST_DIV;
          r_iter  <= '0;
        end
        ST_DIV: begin
          r_iter <= r_iter + 1'b1;
          if (r_iter == LAST_ITER) begin
            r_state   <= ST_WRITE;
            r_wt_en   <= 1'b1;
            r_wt_addr <= r_index;
          end
        end
        ST_WRITE: begin
          r_wt_en <= 1'b0;
          if (r_index == LAST_IDX) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            // Read address is registered here so it is valid throughout READ.
            r_index   <= r_index + 1'b1;
            r_rd_addr <= r_index + 1'b1;
            r_state   <= ST_READ;
          end
        end
        ST_DONE: r_state <= ST_DONE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    div_scale_lane #(
      .WORD_W (WORD_W),
      .SCALE  (SCALE)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_load),
      .i_step    (w_step),
      .i_a       (div_sc_mem_rd_data1[g*WORD_W +: WORD_W]),
      .i_b       (div_sc_mem_rd_data2[g*WORD_W +: WORD_W]),
      .i_cdf_min (cdf_min),
      .o_q       (div_sc_mem_wt_data[g*WORD_W +: WORD_W])
    );
  end

  assign div_sc_mem_rd_addr1 = r_rd_addr;
  assign div_sc_mem_rd_addr2 = r_rd_addr;
  assign div_sc_mem_wt_addr  = r_wt_addr;
  assign div_sc_mem_wt_en    = r_wt_en;
  assign div_sc_mem_rd_done  = r_done;
  assign div_sc_mem_wt_done  = r_done;

endmodule

// File: tb/tb_div_scale_engine.sv
// Scoreboard bench: directed per-lane vectors, abort, reset and 8x16 build.
`timescale 1ns/1ps
module tb_div_scale_engine;

  localparam int LANES = 4, WORD_W = 32, ADDR_W = 16, NUM_WORDS = 64, SCALE = 255;
  localparam int DW = LANES * WORD_W;
  localparam int WORD_CYC = 43;

  // Hand-computed vectors at cdf_min=1: q = floor((a-1)*255/(b-1)), clamped/saturated.
  localparam logic [31:0] VA [8] = '{32'h961,  32'h12C1, 32'h100, 32'h0,    32'h65, 32'h1001, 32'h3,   32'h2};
  localparam logic [31:0] VB [8] = '{32'h12C1, 32'h961,  32'h1,   32'h12C1, 32'hFF, 32'h1001, 32'h1F5, 32'h1F5};
  localparam logic [31:0] VQ [8] = '{32'h7F,   32'hFF,   32'hFF,  32'h00,   32'h64, 32'hFF,   32'h01,  32'h00};

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset, enable, enable8;
  logic [WORD_W-1:0] cdf_min;
  logic [DW-1:0]     rd_data1, rd_data2, wt_data;
  logic [ADDR_W-1:0] rd_addr1, rd_addr2, wt_addr;
  logic              wt_en, rd_done, wt_done;

  logic [127:0]      d8_a = {8{16'h0961}};
  logic [127:0]      d8_b = {8{16'h12C1}};
  logic [15:0]       cdf8 = 16'h0001;
  logic [127:0]      wt_data8;
  logic [ADDR_W-1:0] rd_a81, rd_a82, wt_addr8;
  logic              wt_en8, rd_done8, wt_done8;

  wr_t exp_q[$];
  int  n_cmp = 0, n_bad = 0, cyc = 0, last_wr_cyc = -1, w8_cnt = 0;
  logic exp_done = 1'b0, exp_done8 = 1'b0, rst_pending = 1'b0, final_chk = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_scale_engine #(.LANES(LANES), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .NUM_WORDS(NUM_WORDS), .SCALE(SCALE)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .cdf_min(cdf_min),
    .div_sc_mem_rd_data1(rd_data1), .div_sc_mem_rd_data2(rd_data2),
    .div_sc_mem_rd_addr1(rd_addr1), .div_sc_mem_rd_addr2(rd_addr2),
    .div_sc_mem_wt_data(wt_data), .div_sc_mem_wt_addr(wt_addr), .div_sc_mem_wt_en(wt_en),
    .div_sc_mem_rd_done(rd_done), .div_sc_mem_wt_done(wt_done));

  div_scale_engine #(.LANES(8), .WORD_W(16), .ADDR_W(ADDR_W), .NUM_WORDS(2), .SCALE(SCALE)) u_dut8 (
    .clk(clk), .reset(reset), .enable(enable8), .cdf_min(cdf8),
    .div_sc_mem_rd_data1(d8_a), .div_sc_mem_rd_data2(d8_b),
    .div_sc_mem_rd_addr1(rd_a81), .div_sc_mem_rd_addr2(rd_a82),
    .div_sc_mem_wt_data(wt_data8), .div_sc_mem_wt_addr(wt_addr8), .div_sc_mem_wt_en(wt_en8),
    .div_sc_mem_rd_done(rd_done8), .div_sc_mem_wt_done(wt_done8));

  // sel 0: numerator word, 1: divisor word, 2: expected result word
  function automatic logic [DW-1:0] mk_word(input int w, input int sel);
    logic [DW-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      case (sel)
        0:       r[l*WORD_W +: WORD_W] = VA[(w + l) % 8];
        1:       r[l*WORD_W +: WORD_W] = VB[(w + l) % 8];
        default: r[l*WORD_W +: WORD_W] = VQ[(w + l) % 8];
      endcase
    end
    return r;
  endfunction

  // Memory model: data returned one cycle after the address.
  always @(posedge clk) begin
    rd_data1 <= mk_word(int'(rd_addr1), 0);
    rd_data2 <= mk_word(int'(rd_addr2), 1);
  end

  task automatic push_words(input int first, input int last);
    wr_t t;
    for (int w = first; w <= last; w++) begin
      t.addr = ADDR_W'(w);
      t.data = mk_word(w, 2);
      exp_q.push_back(t);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    n_cmp++;
    if (rd_done !== exp_done || wt_done !== exp_done) begin
      n_bad++;
      $display("FAIL done_flags: rd_done=%b wt_done=%b required %b (cycle %0d)", rd_done, wt_done, exp_done, cyc);
    end
    n_cmp++;
    if (rd_done8 !== exp_done8 || wt_done8 !== exp_done8) begin
      n_bad++;
      $display("FAIL done_flags_8x16: rd_done=%b wt_done=%b required %b (cycle %0d)", rd_done8, wt_done8, exp_done8, cyc);
    end
    if (rst_pending) begin
      n_cmp++;
      if (rd_addr1 !== '0 || rd_addr2 !== '0 || wt_addr !== '0 || wt_data !== '0 || wt_en !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_state: rd_addr=%h/%h wt_addr=%h wt_en=%b wt_data=%h required all zero",
                 rd_addr1, rd_addr2, wt_addr, wt_en, wt_data);
      end
    end
    if (wt_en === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: addr=%0d data=%h required no write", wt_addr, wt_data);
      end else begin
        e = exp_q.pop_front();
        if (wt_addr !== e.addr || rd_addr1 !== e.addr || rd_addr2 !== e.addr || wt_data !== e.data) begin
          n_bad++;
          $display("FAIL write_word: addr=%0d rd=%0d/%0d data=%h required addr=%0d data=%h",
                   wt_addr, rd_addr1, rd_addr2, wt_data, e.addr, e.data);
        end
      end
      if (wt_addr != '0 && last_wr_cyc >= 0) begin
        n_cmp++;
        if (cyc - last_wr_cyc != WORD_CYC) begin
          n_bad++;
          $display("FAIL write_spacing: %0d cycles required %0d at addr %0d", cyc - last_wr_cyc, WORD_CYC, wt_addr);
        end
      end
      last_wr_cyc = cyc;
    end
    if (wt_en8 === 1'b1) begin
      n_cmp++;
      if (wt_data8 !== {8{16'h007F}} || wt_addr8 !== ADDR_W'(w8_cnt) || rd_a81 !== wt_addr8 || rd_a82 !== wt_addr8) begin
        n_bad++;
        $display("FAIL write_8x16: addr=%0d data=%h required addr=%0d data=%h",
                 wt_addr8, wt_data8, w8_cnt, {8{16'h007F}});
      end
      w8_cnt++;
    end
    if (final_chk) begin
      n_cmp++;
      if (exp_q.size() != 0 || w8_cnt != 2) begin
        n_bad++;
        $display("FAIL final_counts: pending=%0d writes_8x16=%0d required 0 and 2", exp_q.size(), w8_cnt);
      end
    end
    exp_done    = reset ? 1'b0 : !enable ? 1'b0 : (wt_en === 1'b1 && wt_addr == ADDR_W'(NUM_WORDS - 1)) ? 1'b1 : exp_done;
    exp_done8   = reset ? 1'b0 : !enable8 ? 1'b0 : (wt_en8 === 1'b1 && wt_addr8 == ADDR_W'(1)) ? 1'b1 : exp_done8;
    rst_pending = reset;
  end

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    enable8 = 1'b0;
    cdf_min = 32'd1;
    step(3);

    // Run 1: cdf_min disturbed after word 0 is loaded, abort mid-DIV of word 5.
    reset   = 1'b0;
    push_words(0, 4);
    enable  = 1'b1;
    enable8 = 1'b1;
    step(3);
    cdf_min = 32'h9999;
    step(10);
    cdf_min = 32'd1;
    step(223);
    enable = 1'b0;
    step(20);

    // Run 2: full pass from address 0 through DONE, then release.
    push_words(0, NUM_WORDS - 1);
    enable = 1'b1;
    step(NUM_WORDS * WORD_CYC + 8);
    enable  = 1'b0;
    enable8 = 1'b0;
    step(3);

    // Run 3: reset during DIV with enable held high, then one word after release.
    enable = 1'b1;
    step(20);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    push_words(0, 0);
    step(WORD_CYC + 5);
    enable = 1'b0;
    step(3);

    final_chk = 1'b1;
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
